ring_arbiter: RTL
=================

# ring_arbiter

Round-robin arbiter that shares one resource among N requesters using a rotating one-hot priority pointer (ring counter). Sits between the requesting blocks and the shared datapath; its registered one-hot grant drives the resource's select/enable lines directly. Grants are exclusive and bounded by a hold timeout, with a guaranteed idle cycle between consecutive grants.

## Interface
- N, 4: number of requesters (2..16).
- MAX_HOLD, 8: maximum grant length in cycles; 0 disables the timeout.
- IDW, $clog2(N): width of gnt_idx (derived, not overridden).

- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately when low.
- req  input  N  level request per requester; bit i = requester i.
- rel  input  1  release strobe from the current grant holder; ignored when no grant is active.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_vld  output  1  high while any gnt bit is high (equals |gnt).
- gnt_idx  output  IDW  binary index of granted requester; holds last winner when idle.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State: IDLE, GRANT. Internal ptr (N-bit one-hot ring), hold_cnt (counter up to MAX_HOLD), winner index.
- Reset (rst low): state=IDLE, gnt=0, gnt_vld=0, gnt_idx=0, timeout=0, ptr=one-hot bit 0, hold_cnt=0.
- IDLE: if req != 0, winner = first set req bit scanning circularly from ptr's bit upward (ptr bit itself has highest priority, wrapping N-1 -> 0). Next state GRANT, gnt=onehot(winner), gnt_idx=winner, hold_cnt=0. If req == 0, stay IDLE, outputs unchanged.
- GRANT: hold_cnt increments each cycle. Grant ends on the first edge where any of:
  - rel=1 (release);
  - req[winner]=0 (requester withdrew);
  - MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 (grant has lasted MAX_HOLD cycles).
- On grant end: gnt=0, state=IDLE, ptr = winner one-hot rotated left by 1 (bit N-1 wraps to bit 0). timeout=1 for that one cycle only if end cause is the hold limit alone.
- Priority of end causes: rel or req drop take precedence; timeout is not pulsed if rel=1 or req[winner]=0 on the same edge.
- Requests from other requesters during GRANT have no effect on gnt; they are arbitrated in the following IDLE cycle.
- ptr never changes except at grant end; it is always exactly one-hot.
- gnt is always one-hot or zero; never two bits high.

## Timing
- Grant latency: req sampled high at edge k in IDLE -> gnt high after edge k (1 cycle).
- Release latency: rel sampled high at edge k -> gnt low after edge k.
- Mandatory bubble: after any grant ends, gnt is zero for at least 1 full cycle; next grant earliest after the following edge (back-to-back grant spacing = 1 idle cycle).
- Timeout: with MAX_HOLD=M, an unreleased grant is high for exactly M cycles; timeout pulses in the first cycle gnt is low.
- rel in IDLE or the cycle a grant is being issued is ignored (no effect on ptr).
- rst asserted mid-grant: gnt, gnt_vld, timeout go low immediately (asynchronous), ptr returns to bit 0; deassertion is sampled synchronously, first grant possible at the second posedge after rst rises.

## Test plan
- Reset: rst low with req=4'b1111 -> gnt=0, gnt_vld=0, gnt_idx=0, timeout=0; after release, first grant is requester 0.
- Single requester: req=4'b0100 held, rel pulsed after 3 cycles -> gnt=4'b0100 one cycle after req, low after rel, one idle cycle, then regranted to 2 (ptr=4'b1000, only req 2 pending).
- Round-robin fairness: req=4'b1111 held, rel pulsed each grant -> grant order 0,1,2,3,0,1 with one idle cycle between each.
- Wrap-around and skip: ptr at bit 3, req=4'b0011 -> grant 0, then 1; req=4'b1001 after grant to 3 -> grant 0.
- Timeout: MAX_HOLD=8, req=4'b0010 held, no rel -> gnt high exactly 8 cycles, timeout=1 for one cycle as gnt falls, rel coincident with limit edge -> timeout stays 0.
- Reset mid-grant / req drop: drop req[winner] during grant -> gnt low next edge, no timeout; assert rst during grant -> gnt cleared without waiting for clk.

Source files
------------

// File: rtl/ring_arbiter_if.sv
// Request/grant bundle between the requesting blocks and ring_arbiter.
// master drives requests/release; slave returns the one-hot grant.
interface ring_arbiter_if #(
    parameter int N = 4
) ();
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           rel;
    logic [N-1:0]   gnt;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic           timeout;

    modport master (
        output req, rel,
        input  gnt, gnt_vld, gnt_idx, timeout
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_vld, gnt_idx, timeout
    );
endinterface

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer,
// exclusive registered grants, hold timeout and a forced idle bubble.
module ring_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    ring_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           tmo_q, tmo_d;
    logic           rst_q;

    logic [IDW-1:0] pidx;
    logic [IDW-1:0] win;
    logic           found;
    logic           at_lim;
    logic           drop;

    // Assert immediately, release one edge after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_q <= 1'b0;
        else      rst_q <= 1'b1;
    end

    always_comb begin
        pidx  = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[i]) pidx = IDW'(i);
        end
        // Descending scan so the lowest offset from ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[(int'(pidx) + k) % N]) begin
                win   = IDW'((int'(pidx) + k) % N);
                found = 1'b1;
            end
        end
    end

    assign at_lim = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign drop   = !bus.req[idx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
                    idx_d   = win;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (bus.rel || drop || at_lim) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = {gnt_q[N-2:0], gnt_q[N-1]};
                    tmo_d   = at_lim && !bus.rel && !drop;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_q) begin
        if (!rst_q) begin
            state_q <= IDLE;
            ptr_q   <= {{(N-1){1'b0}}, 1'b1};
            gnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_vld = |gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.timeout = tmo_q;
endmodule
